enemy_wave_controller: RTL and testbench
========================================

// Module: enemy_wave_controller
// PURPOSE
// - Sequences a wave of NUM_ENEMIES enemy motion instances: staggered spawn, per-enemy random steering bit,
//   kill/death timing and level-clear detection.
// - Sits between game control and the enemy instances: drives their per-slot resetN and random inputs,
//   gates their drawing/collision, and reports kills to the score logic.
// PARAMETERS
// - NUM_ENEMIES   4        enemy slots managed (1..8)
// - SPAWN_GAP     60       frames between consecutive spawns (>=1)
// - DEATH_FRAMES  30       frames a killed enemy stays in the dying animation before removal (>=1)
// - LFSR_SEED     16'hACE1 non-zero reset value of the 16-bit LFSR
// PORTS
// - clk             in   1            system clock
// - resetN          in   1            asynchronous active-low reset
// - startOfFrame    in   1            one-cycle pulse per frame
// - start_wave      in   1            one-cycle pulse: begin a new wave (ignored unless IDLE or CLEAR)
// - enemy_hit       in   NUM_ENEMIES  per-slot kill request (explosion overlap), level, sampled every clk
// - enemy_resetN    out  NUM_ENEMIES  per-slot active-low reset to enemy instance; 0 = held at spawn point
// - enemy_alive     out  NUM_ENEMIES  slot is moving and collidable
// - enemy_dying     out  NUM_ENEMIES  slot shows death animation; not collidable
// - enemy_random    out  NUM_ENEMIES  per-slot steering bit, stable for a whole frame
// - kill_pulse      out  1            one-cycle pulse per kill accepted
// - kill_count      out  8            kills this wave, saturates at 255
// - wave_clear      out  1            level: every slot spawned and removed
// BEHAVIOUR
// - Reset: all outputs 0 (enemy_resetN = all 0), FSM IDLE, frame counter 0, LFSR = LFSR_SEED.
// - Top FSM states: IDLE, SPAWN, RUN, CLEAR.
//   IDLE  --start_wave--> SPAWN. Clears kill_count; spawn index and frame counter reset to 0.
//   SPAWN: slot 0 spawns on the first startOfFrame after entry. After that, on each startOfFrame the
//     counter increments; when it reaches SPAWN_GAP, the next slot spawns and the counter returns to 0.
//     After slot NUM_ENEMIES-1 spawns --> RUN.
//   RUN: when no slot is alive or dying --> CLEAR.
//   CLEAR: wave_clear=1. start_wave --> SPAWN (new wave). wave_clear drops the cycle after start_wave.
// - Per-slot state: OFF -> ALIVE -> DYING -> DEAD. Encodings live in the package.
//   spawn: OFF->ALIVE; enemy_resetN[i] rises 1 clk after the spawning startOfFrame edge.
//     The enemy's own IDLE state latches its start on the following startOfFrame.
//   ALIVE & enemy_hit[i]: ->DYING. kill_pulse=1 for exactly 1 clk; kill_count++ (saturating).
//     Per-slot death counter cleared.
//   DYING: counter++ per startOfFrame; at DEATH_FRAMES ->DEAD and enemy_resetN[i]=0.
//   enemy_hit while OFF, DYING or DEAD: ignored, no kill_pulse.
//   Simultaneous hits on k slots in one clk: all transition; kill_count += k (saturating).
//     kill_pulse is a single 1-clk pulse.
// - enemy_resetN[i]=1 only in ALIVE or DYING. The enemy position therefore freezes only by resetting when DEAD.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk.
//   On startOfFrame, enemy_random[i] <= lfsr[i] (registered). Held constant between frames.
// - start_wave while SPAWN/RUN: ignored. resetN low mid-wave: immediate return to reset values.
// - Spawn and kill for a different slot in the same cycle: both take effect.
// - All counters sized by $clog2 of their parameter +1; no wrap in normal operation.
// STRUCTURE
// - Package enemy_wave_pkg holds:
//   - the top-FSM enum and the per-slot enum (OFF/ALIVE/DYING/DEAD);
//   - the LFSR tap constant.
// - Sub-module enemy_slot_fsm (one per slot, generate loop) implements:
//   - the per-slot state and death counter;
//   - the enemy_resetN / alive / dying outputs;
//   - its own kill pulse.
// - Top-level logic ORs/sums the slot kill pulses.
// - Top module keeps the top FSM, spawn counter, LFSR and kill_count.
// TESTING
// - Reset then idle 10 frames with no start_wave -> all outputs 0, wave_clear=0.
// - start_wave, SPAWN_GAP=3 -> enemy_resetN goes 0001, 0011, 0111, 1111 at frames 1, 4, 7, 10.
//   FSM reaches RUN after the last spawn.
// - Hit slot 2 while ALIVE -> kill_pulse 1 clk, kill_count=1, enemy_dying[2]=1.
//   After DEATH_FRAMES=30 frames, enemy_resetN[2]=0. A second hit on slot 2 during DYING gives no pulse.
// - Hits on slots 0 and 3 in the same clk -> kill_count +2, one kill_pulse.
//   Kill all 4 -> wave_clear=1 after the last death timer expires.
// - Check enemy_random changes only the clk after startOfFrame and matches an LFSR reference model.
//   Then assert resetN mid-RUN -> all outputs 0 and LFSR=16'hACE1.

Source files
------------

// File: rtl/enemy_wave_pkg.sv
// Shared types and constants for the enemy wave controller and its per-slot state machines.
package enemy_wave_pkg;

    typedef enum logic [1:0] {
        WaveIdle,
        WaveSpawn,
        WaveRun,
        WaveClear
    } wave_state_e;

    typedef enum logic [1:0] {
        SlotOff,
        SlotAlive,
        SlotDying,
        SlotDead
    } slot_state_e;

    // Fibonacci taps at stages 16, 14, 13 and 11.
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/enemy_slot_fsm.sv
// One enemy slot: OFF -> ALIVE -> DYING -> DEAD with a frame-based death timer and a kill pulse.
module enemy_slot_fsm
    import enemy_wave_pkg::*;
#(
    parameter int unsigned DeathFrames = 30
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sof_i,
    input  logic clear_i,
    input  logic spawn_i,
    input  logic hit_i,
    output logic reset_n_o,
    output logic alive_o,
    output logic dying_o,
    output logic kill_o
);

    localparam int unsigned CntW = $clog2(DeathFrames) + 1;

    slot_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            kill_q, kill_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = 1'b0;
        if (clear_i) begin
            state_d = SlotOff;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                SlotOff: begin
                    if (spawn_i) state_d = SlotAlive;
                end
                SlotAlive: begin
                    if (hit_i) begin
                        state_d = SlotDying;
                        cnt_d   = '0;
                        kill_d  = 1'b1;
                    end
                end
                SlotDying: begin
                    // The frame that would bring the count to DeathFrames removes the enemy.
                    if (sof_i) begin
                        if (cnt_q == CntW'(DeathFrames - 1)) state_d = SlotDead;
                        else                                 cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SlotOff;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    assign alive_o   = (state_q == SlotAlive);
    assign dying_o   = (state_q == SlotDying);
    assign reset_n_o = alive_o | dying_o;
    assign kill_o    = kill_q;

endmodule

// File: rtl/enemy_wave_controller.sv
// Wave sequencer: staggered spawning, per-frame random steering bits, kill counting and
// level-clear detection for NUM_ENEMIES enemy slots.
module enemy_wave_controller
    import enemy_wave_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES  = 4,
    parameter int unsigned SPAWN_GAP    = 60,
    parameter int unsigned DEATH_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   start_wave,
    input  logic [NUM_ENEMIES-1:0] enemy_hit,
    output logic [NUM_ENEMIES-1:0] enemy_resetN,
    output logic [NUM_ENEMIES-1:0] enemy_alive,
    output logic [NUM_ENEMIES-1:0] enemy_dying,
    output logic [NUM_ENEMIES-1:0] enemy_random,
    output logic                   kill_pulse,
    output logic [7:0]             kill_count,
    output logic                   wave_clear
);

    localparam int unsigned GapW = $clog2(SPAWN_GAP) + 1;
    localparam int unsigned IdxW = $clog2(NUM_ENEMIES) + 1;

    wave_state_e            state_q, state_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [7:0]             kill_count_q, kill_count_d;
    logic [8:0]             kill_sum;
    logic [15:0]            lfsr_q;
    logic [NUM_ENEMIES-1:0] random_q;
    logic [NUM_ENEMIES-1:0] spawn;
    logic [NUM_ENEMIES-1:0] slot_kill;
    logic                   slot_clear;

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        spawn      = '0;
        slot_clear = 1'b0;
        unique case (state_q)
            WaveIdle, WaveClear: begin
                if (start_wave) begin
                    state_d    = WaveSpawn;
                    gap_d      = '0;
                    idx_d      = '0;
                    slot_clear = 1'b1;
                end
            end
            WaveSpawn: begin
                // Slot 0 goes on the first frame; later slots wait SPAWN_GAP frames each.
                if (startOfFrame) begin
                    if (idx_q == '0 || gap_q == GapW'(SPAWN_GAP - 1)) begin
                        spawn = NUM_ENEMIES'(1) << idx_q;
                        gap_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IdxW'(NUM_ENEMIES - 1)) state_d = WaveRun;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            WaveRun: begin
                if ((enemy_alive | enemy_dying) == '0) state_d = WaveClear;
            end
            default: ;
        endcase
    end

    always_comb begin
        kill_sum = {1'b0, kill_count_q};
        for (int i = 0; i < NUM_ENEMIES; i++) kill_sum = kill_sum + 9'(slot_kill[i]);
        kill_count_d = kill_sum[8] ? 8'hFF : kill_sum[7:0];
        if (slot_clear) kill_count_d = '0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= WaveIdle;
            gap_q        <= '0;
            idx_q        <= '0;
            kill_count_q <= '0;
            lfsr_q       <= LFSR_SEED;
            random_q     <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            kill_count_q <= kill_count_d;
            lfsr_q       <= lfsr_next(lfsr_q);
            if (startOfFrame) random_q <= lfsr_q[NUM_ENEMIES-1:0];
        end
    end

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
        enemy_slot_fsm #(
            .DeathFrames(DEATH_FRAMES)
        ) u_slot (
            .clk_i    (clk),
            .rst_ni   (resetN),
            .sof_i    (startOfFrame),
            .clear_i  (slot_clear),
            .spawn_i  (spawn[i]),
            .hit_i    (enemy_hit[i]),
            .reset_n_o(enemy_resetN[i]),
            .alive_o  (enemy_alive[i]),
            .dying_o  (enemy_dying[i]),
            .kill_o   (slot_kill[i])
        );
    end

    assign enemy_random = random_q;
    assign kill_pulse   = |slot_kill;
    assign kill_count   = kill_count_q;
    assign wave_clear   = (state_q == WaveClear);

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Randomized bench for enemy_wave_controller against a frame-level model of spawns, kills and deaths.
module tb_enemy_wave_controller;

    localparam int N   = 4;
    localparam int Gap = 3;
    localparam int Df  = 30;

    logic         clk          = 1'b0;
    logic         resetN       = 1'b1;
    logic         startOfFrame = 1'b0;
    logic         start_wave   = 1'b0;
    logic [N-1:0] enemy_hit    = '0;
    logic [N-1:0] enemy_resetN, enemy_alive, enemy_dying, enemy_random;
    logic         kill_pulse;
    logic [7:0]   kill_count;
    logic         wave_clear;

    enemy_wave_controller #(
        .NUM_ENEMIES (N),
        .SPAWN_GAP   (Gap),
        .DEATH_FRAMES(Df),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .start_wave  (start_wave),
        .enemy_hit   (enemy_hit),
        .enemy_resetN(enemy_resetN),
        .enemy_alive (enemy_alive),
        .enemy_dying (enemy_dying),
        .enemy_random(enemy_random),
        .kill_pulse  (kill_pulse),
        .kill_count  (kill_count),
        .wave_clear  (wave_clear)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Frame-level model: a frame's SOF comes first, then any hit or start_wave.
    int  frame_no = 0;
    bit  wave_on  = 1'b0;
    int  wave_f   = 0;
    int  kill_f[N];
    int  kills    = 0;

    logic [15:0]  m_lfsr;
    logic [N-1:0] m_rand;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lfsr <= 16'hACE1;
            m_rand <= '0;
        end else begin
            if (startOfFrame) m_rand <= m_lfsr[N-1:0];
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic bit m_spawned(int i);
        return wave_on && (frame_no >= wave_f + 1 + i * Gap);
    endfunction

    function automatic bit m_alive(int i);
        return m_spawned(i) && (kill_f[i] < 0);
    endfunction

    function automatic bit m_dying(int i);
        return wave_on && (kill_f[i] >= 0) && (frame_no < kill_f[i] + Df);
    endfunction

    function automatic bit m_clear();
        bit c = wave_on;
        for (int i = 0; i < N; i++) if (!m_spawned(i) || m_alive(i) || m_dying(i)) c = 1'b0;
        return c;
    endfunction

    // {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}
    function automatic logic [3*N+8:0] m_outputs();
        logic [N-1:0] a, d;
        for (int i = 0; i < N; i++) begin
            a[i] = m_alive(i);
            d[i] = m_dying(i);
        end
        return {a | d, a, d, (kills > 255) ? 8'hFF : 8'(kills), m_clear()};
    endfunction

    function automatic void m_reset();
        wave_on = 1'b0;
        kills   = 0;
        for (int i = 0; i < N; i++) kill_f[i] = -1;
    endfunction

    // Drives one frame (SOF at cycle 0, hit/start at cycle 1) and updates the model.
    task automatic run_frame(input logic [N-1:0] hv, input bit start,
                             output int pulses, output int exp_pulses);
        int           len       = $urandom_range(5, 8);
        bit           can_start = !wave_on || m_clear();
        logic [N-1:0] acc       = '0;
        pulses = 0;
        frame_no++;
        for (int i = 0; i < N; i++) if (hv[i] && m_alive(i)) acc[i] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                kill_f[i] = frame_no;
                kills++;
            end
        end
        exp_pulses = (acc != '0) ? 1 : 0;
        if (start && can_start) begin
            m_reset();
            wave_on = 1'b1;
            wave_f  = frame_no;
        end
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (kill_pulse === 1'b1) pulses++;
            startOfFrame = (c == 0);
            start_wave   = start && (c == 1);
            enemy_hit    = (c == 1) ? hv : '0;
        end
    endtask

    task automatic test_reset();
        int p, ep;
        resetN = 1'b1;
        #2 resetN = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({enemy_resetN, enemy_alive, enemy_dying, enemy_random, kill_pulse, kill_count,
             wave_clear} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rstN=%b alive=%b dying=%b rnd=%b kp=%b cnt=%0d clr=%b want all 0",
                     enemy_resetN, enemy_alive, enemy_dying, enemy_random, kill_pulse,
                     kill_count, wave_clear);
        end
        resetN = 1'b1;
        for (int f = 0; f < 10; f++) begin
            run_frame('0, 1'b0, p, ep);
            vectors++;
            if ({enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear} !== m_outputs()) begin
                miscompares++;
                $display("FAIL idle_outputs frame %0d: got %h want %h", frame_no,
                         {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}, m_outputs());
            end
            vectors++;
            if (p !== 0) begin
                miscompares++;
                $display("FAIL idle_kill_pulse frame %0d: got %0d pulses want 0", frame_no, p);
            end
        end
    endtask

    task automatic test_lfsr(input int frames);
        for (int f = 0; f < frames; f++) begin
            int len = $urandom_range(2, 6);
            frame_no++;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                vectors++;
                if (enemy_random !== m_rand) begin
                    miscompares++;
                    $display("FAIL enemy_random frame %0d cyc %0d: got %b want %b",
                             frame_no, c, enemy_random, m_rand);
                end
                startOfFrame = (c == 0);
            end
        end
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic test_spawn();
        int p, ep;
        run_frame('0, 1'b1, p, ep);
        vectors++;
        if ({enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear} !== m_outputs()) begin
            miscompares++;
            $display("FAIL spawn_start: got %h want %h",
                     {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}, m_outputs());
        end
        // Frame 1 by hand: enemy_resetN[0] must rise right after the SOF edge.
        @(negedge clk);
        startOfFrame = 1'b1;
        frame_no++;
        @(negedge clk);
        startOfFrame = 1'b0;
        vectors++;
        if (enemy_resetN !== 4'b0001) begin
            miscompares++;
            $display("FAIL spawn_first_rise: got %b want 0001", enemy_resetN);
        end
        repeat ($urandom_range(3, 6)) @(negedge clk);
        for (int f = 2; f <= 10; f++) begin
            run_frame('0, (f == 5), p, ep);
            vectors++;
            if ({enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear} !== m_outputs()) begin
                miscompares++;
                $display("FAIL spawn_frame %0d: got %h want %h", f,
                         {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}, m_outputs());
            end
        end
        vectors++;
        if (enemy_resetN !== 4'b1111) begin
            miscompares++;
            $display("FAIL spawn_all: got %b want 1111", enemy_resetN);
        end
    endtask

    task automatic test_kill();
        int p, ep;
        logic [N-1:0] hv[6] = '{4'b0100, 4'b0100, 4'b1001, 4'b0000, 4'b0010, 4'b1111};
        for (int s = 0; s < 6; s++) begin
            run_frame(hv[s], (s == 3), p, ep);
            vectors++;
            if (p !== ep) begin
                miscompares++;
                $display("FAIL kill_pulse step %0d: got %0d pulses want %0d", s, p, ep);
            end
            vectors++;
            if ({enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear} !== m_outputs()) begin
                miscompares++;
                $display("FAIL kill_state step %0d: got %h want %h", s,
                         {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}, m_outputs());
            end
        end
        vectors++;
        if (kill_count !== 8'd4) begin
            miscompares++;
            $display("FAIL kill_count_total: got %0d want 4", kill_count);
        end
        for (int f = 0; f < 40; f++) begin
            run_frame('0, 1'b0, p, ep);
            vectors++;
            if ({enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear} !== m_outputs()) begin
                miscompares++;
                $display("FAIL death_timer frame %0d: got %h want %h", frame_no,
                         {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}, m_outputs());
            end
        end
        vectors++;
        if (wave_clear !== 1'b1) begin
            miscompares++;
            $display("FAIL wave_clear_final: got %b want 1", wave_clear);
        end
    endtask

    task automatic test_random_waves(input int frames);
        int p, ep;
        for (int f = 0; f < frames; f++) begin
            logic [N-1:0] hv = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            bit st = (hv == '0) && ($urandom_range(0, 3) == 0);
            run_frame(hv, st, p, ep);
            vectors++;
            if (p !== ep) begin
                miscompares++;
                $display("FAIL rnd_kill_pulse frame %0d: got %0d pulses want %0d", frame_no, p, ep);
            end
            vectors++;
            if ({enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear} !== m_outputs()) begin
                miscompares++;
                $display("FAIL rnd_state frame %0d hit %b: got %h want %h", frame_no, hv,
                         {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}, m_outputs());
            end
        end
    endtask

    task automatic test_midrun_reset();
        int p, ep;
        if (!wave_on || m_clear()) run_frame('0, 1'b1, p, ep);
        for (int f = 0; f < 11; f++) run_frame('0, 1'b0, p, ep);
        test_lfsr(3);
        @(negedge clk);
        resetN = 1'b0;
        m_reset();
        #1;
        vectors++;
        if ({enemy_resetN, enemy_alive, enemy_dying, enemy_random, kill_pulse, kill_count,
             wave_clear} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got rstN=%b alive=%b dying=%b rnd=%b kp=%b cnt=%0d clr=%b want all 0",
                     enemy_resetN, enemy_alive, enemy_dying, enemy_random, kill_pulse,
                     kill_count, wave_clear);
        end
        @(negedge clk);
        resetN       = 1'b1;
        startOfFrame = 1'b1;
        frame_no++;
        @(negedge clk);
        startOfFrame = 1'b0;
        vectors++;
        if (enemy_random !== 4'b0001) begin
            miscompares++;
            $display("FAIL seed_after_reset: got %b want 0001", enemy_random);
        end
        vectors++;
        if ({enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear} !== m_outputs()) begin
            miscompares++;
            $display("FAIL post_reset_state: got %h want %h",
                     {enemy_resetN, enemy_alive, enemy_dying, kill_count, wave_clear}, m_outputs());
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) kill_f[i] = -1;
        test_reset();
        test_lfsr(6);
        test_spawn();
        test_kill();
        test_random_waves(200);
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
